// File: rtl/pong_engine.sv
// Two-player pong game-state core: ball, paddles, scores and match FSM, advanced once per tick.
// Optional feature macro: PONG_BOOST_EN (paddle speed grows while a single button is held).
module pong_engine #(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int XW          = 10,
    parameter int YW          = 9,
    parameter int BORDER      = 8,
    parameter int BALL_SIZE   = 16,
    parameter int PADDLE_LEN  = 112,
    parameter int BALL_SPEED  = 2,
    parameter int PADDLE_STEP = 4,
    parameter int SERVE_TICKS = 60,
    parameter int SCORE_W     = 4,
    parameter int WIN_SCORE   = 9
) (
    input  logic               CLOCK_50,
    input  logic               RESET,
    input  logic               tick,
    input  logic               start,
    input  logic               p0_left,
    input  logic               p0_right,
    input  logic               p1_left,
    input  logic               p1_right,
    output logic [XW-1:0]      ball_x,
    output logic [YW-1:0]      ball_y,
    output logic [XW-1:0]      paddle0_x,
    output logic [XW-1:0]      paddle1_x,
    output logic [SCORE_W-1:0] score0,
    output logic [SCORE_W-1:0] score1,
    output logic [2:0]         state,
    output logic               point_pulse,
    output logic               winner
);

    localparam int XE    = XW + 2;
    localparam int YE    = YW + 2;
    localparam int CNT_W = (SERVE_TICKS < 2) ? 1 : $clog2(SERVE_TICKS + 1);

    // Widened copies for overflow-free comparisons
    localparam logic [XE-1:0] X_MIN_E      = XE'(BORDER);
    localparam logic [XE-1:0] PAD_MAX_E    = XE'(H_RES - BORDER - PADDLE_LEN);
    localparam logic [XE-1:0] BALL_X_MAX_E = XE'(H_RES - BORDER - BALL_SIZE);
    localparam logic [XE-1:0] BSZ_XE       = XE'(BALL_SIZE);
    localparam logic [XE-1:0] PLEN_XE      = XE'(PADDLE_LEN);
    localparam logic [XE-1:0] SPD_XE       = XE'(BALL_SPEED);
    localparam logic [YE-1:0] BORDER_YE    = YE'(BORDER);
    localparam logic [YE-1:0] SPD_YE       = YE'(BALL_SPEED);
    localparam logic [YE-1:0] BSZ_YE       = YE'(BALL_SIZE);
    localparam logic [YE-1:0] P0Y_YE       = YE'(V_RES - BORDER);
    localparam logic [YE-1:0] Y_MISS_YE    = YE'(V_RES - BALL_SIZE);

    localparam logic [XW-1:0]      X_MIN      = XW'(BORDER);
    localparam logic [XW-1:0]      PAD_MAX    = XW'(H_RES - BORDER - PADDLE_LEN);
    localparam logic [XW-1:0]      BALL_X_MAX = XW'(H_RES - BORDER - BALL_SIZE);
    localparam logic [XW-1:0]      SPD_X      = XW'(BALL_SPEED);
    localparam logic [XW-1:0]      BALL_CX    = XW'((H_RES - BALL_SIZE) / 2);
    localparam logic [XW-1:0]      PAD_C      = XW'((H_RES - PADDLE_LEN) / 2);
    localparam logic [YW-1:0]      SPD_Y      = YW'(BALL_SPEED);
    localparam logic [YW-1:0]      Y_TOP      = YW'(BORDER);
    localparam logic [YW-1:0]      Y_BOT      = YW'(V_RES - BORDER - BALL_SIZE);
    localparam logic [YW-1:0]      BALL_CY    = YW'((V_RES - BALL_SIZE) / 2);
    localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_TICKS);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ZERO   = CNT_W'(0);
    localparam logic [SCORE_W-1:0] SC_ONE     = SCORE_W'(1);
    localparam logic [SCORE_W-1:0] SC_ZERO    = SCORE_W'(0);
    localparam logic [SCORE_W-1:0] SC_WIN     = SCORE_W'(WIN_SCORE);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    state_t             state_r, state_s;
    logic [XW-1:0]      ball_x_r, ball_x_s, paddle0_r, paddle0_s, paddle1_r, paddle1_s;
    logic [YW-1:0]      ball_y_r, ball_y_s;
    logic               dx_right_r, dx_right_s, dy_down_r, dy_down_s;
    logic [SCORE_W-1:0] score0_r, score0_s, score1_r, score1_s, pt_score_s;
    logic               winner_r, winner_s, scorer_r, scorer_s;
    logic [CNT_W-1:0]   serve_cnt_r, serve_cnt_s;
    logic               point_pulse_r, pulse_s;
    logic [XW-1:0]      step0_s, step1_s;
    logic               ov0_s, ov1_s, hit0_s, hit1_s, miss0_s, miss1_s, x_hi_s, x_lo_s;

    // Clamped paddle move; ambiguous or absent input leaves the paddle in place
    function automatic logic [XW-1:0] paddle_move(input logic [XW-1:0] pos, input logic left,
                                                  input logic right, input logic [XW-1:0] step);
        logic [XW-1:0] res;
        if (right && !left) begin
            if ({2'b00, pos} + {2'b00, step} > PAD_MAX_E) res = PAD_MAX;
            else                                          res = pos + step;
        end else if (left && !right) begin
            if ({2'b00, pos} < X_MIN_E + {2'b00, step}) res = X_MIN;
            else                                        res = pos - step;
        end else begin
            res = pos;
        end
        return res;
    endfunction

`ifdef PONG_BOOST_EN
    logic [5:0] hold0_r, hold1_r;

    function automatic logic [5:0] hold_next(input logic [5:0] h, input logic single);
        logic [5:0] res;
        if (!single)          res = 6'd0;
        else if (h == 6'd63)  res = h;
        else                  res = h + 6'd1;
        return res;
    endfunction

    assign step0_s = XW'(hold0_r[5:3]) + XW'(1);
    assign step1_s = XW'(hold1_r[5:3]) + XW'(1);

    // Per-player hold counters, advanced on every tick
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            hold0_r <= 6'd0;
            hold1_r <= 6'd0;
        end else if (tick) begin
            hold0_r <= hold_next(hold0_r, p0_left ^ p0_right);
            hold1_r <= hold_next(hold1_r, p1_left ^ p1_right);
        end else begin
            hold0_r <= hold0_r;
            hold1_r <= hold1_r;
        end
    end
`else
    assign step0_s = XW'(PADDLE_STEP);
    assign step1_s = XW'(PADDLE_STEP);
`endif

    // Collision terms use the paddle positions held before this tick's move
    assign ov0_s   = ({2'b00, ball_x_r} + BSZ_XE > {2'b00, paddle0_r}) &&
                     ({2'b00, ball_x_r} < {2'b00, paddle0_r} + PLEN_XE);
    assign ov1_s   = ({2'b00, ball_x_r} + BSZ_XE > {2'b00, paddle1_r}) &&
                     ({2'b00, ball_x_r} < {2'b00, paddle1_r} + PLEN_XE);
    assign hit0_s  = dy_down_r && ov0_s &&
                     ({2'b00, ball_y_r} + SPD_YE + BSZ_YE >= P0Y_YE) &&
                     ({2'b00, ball_y_r} + BSZ_YE <= P0Y_YE);
    assign miss0_s = dy_down_r && !hit0_s && ({2'b00, ball_y_r} + SPD_YE >= Y_MISS_YE);
    assign hit1_s  = !dy_down_r && ov1_s &&
                     ({2'b00, ball_y_r} <= BORDER_YE + SPD_YE) &&
                     ({2'b00, ball_y_r} >= BORDER_YE);
    assign miss1_s = !dy_down_r && !hit1_s && (ball_y_r < SPD_Y);
    assign x_hi_s  = dx_right_r && ({2'b00, ball_x_r} + SPD_XE > BALL_X_MAX_E);
    assign x_lo_s  = !dx_right_r && ({2'b00, ball_x_r} < X_MIN_E + SPD_XE);
    assign pt_score_s = (scorer_r ? score1_r : score0_r) + SC_ONE;

    // Next-state and next-register values for the coming tick
    always_comb begin
        state_s     = state_r;
        ball_x_s    = ball_x_r;
        ball_y_s    = ball_y_r;
        dx_right_s  = dx_right_r;
        dy_down_s   = dy_down_r;
        paddle0_s   = paddle0_r;
        paddle1_s   = paddle1_r;
        score0_s    = score0_r;
        score1_s    = score1_r;
        winner_s    = winner_r;
        scorer_s    = scorer_r;
        serve_cnt_s = serve_cnt_r;
        pulse_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                score0_s  = SC_ZERO;
                score1_s  = SC_ZERO;
                ball_x_s  = BALL_CX;
                ball_y_s  = BALL_CY;
                paddle0_s = PAD_C;
                paddle1_s = PAD_C;
                if (start) begin
                    state_s     = ST_SERVE;
                    serve_cnt_s = SERVE_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SERVE: begin
                paddle0_s = paddle_move(paddle0_r, p0_left, p0_right, step0_s);
                paddle1_s = paddle_move(paddle1_r, p1_left, p1_right, step1_s);
                ball_x_s  = BALL_CX;
                ball_y_s  = BALL_CY;
                if (serve_cnt_r <= CNT_ONE) begin
                    state_s     = ST_PLAY;
                    serve_cnt_s = CNT_ZERO;
                end else begin
                    serve_cnt_s = serve_cnt_r - CNT_ONE;
                end
            end
            ST_PLAY: begin
                paddle0_s = paddle_move(paddle0_r, p0_left, p0_right, step0_s);
                paddle1_s = paddle_move(paddle1_r, p1_left, p1_right, step1_s);
                if (x_hi_s) begin
                    ball_x_s   = BALL_X_MAX;
                    dx_right_s = 1'b0;
                end else if (x_lo_s) begin
                    ball_x_s   = X_MIN;
                    dx_right_s = 1'b1;
                end else if (dx_right_r) begin
                    ball_x_s = ball_x_r + SPD_X;
                end else begin
                    ball_x_s = ball_x_r - SPD_X;
                end
                if (hit0_s) begin
                    ball_y_s  = Y_BOT;
                    dy_down_s = 1'b0;
                end else if (hit1_s) begin
                    ball_y_s  = Y_TOP;
                    dy_down_s = 1'b1;
                end else if (miss1_s) begin
                    ball_y_s = {YW{1'b0}};
                end else if (dy_down_r) begin
                    ball_y_s = ball_y_r + SPD_Y;
                end else begin
                    ball_y_s = ball_y_r - SPD_Y;
                end
                // A miss wins over the x reflection: position moves, direction is kept
                if (miss0_s || miss1_s) begin
                    state_s    = ST_POINT;
                    scorer_s   = miss0_s;
                    dx_right_s = dx_right_r;
                end else begin
                    state_s = ST_PLAY;
                end
            end
            ST_POINT: begin
                pulse_s  = 1'b1;
                winner_s = scorer_r;
                if (scorer_r) score1_s = pt_score_s;
                else          score0_s = pt_score_s;
                if (pt_score_s == SC_WIN) begin
                    state_s = ST_OVER;
                end else begin
                    state_s     = ST_SERVE;
                    serve_cnt_s = SERVE_LOAD;
                    ball_x_s    = BALL_CX;
                    ball_y_s    = BALL_CY;
                    dy_down_s   = scorer_r;
                end
            end
            ST_OVER: begin
                if (start) begin
                    state_s    = ST_IDLE;
                    score0_s   = SC_ZERO;
                    score1_s   = SC_ZERO;
                    ball_x_s   = BALL_CX;
                    ball_y_s   = BALL_CY;
                    paddle0_s  = PAD_C;
                    paddle1_s  = PAD_C;
                    dx_right_s = 1'b1;
                    dy_down_s  = 1'b1;
                end else begin
                    state_s = ST_OVER;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Game-state registers: loaded only on tick; the point pulse self-clears
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_r       <= ST_IDLE;
            ball_x_r      <= BALL_CX;
            ball_y_r      <= BALL_CY;
            dx_right_r    <= 1'b1;
            dy_down_r     <= 1'b1;
            paddle0_r     <= PAD_C;
            paddle1_r     <= PAD_C;
            score0_r      <= SC_ZERO;
            score1_r      <= SC_ZERO;
            winner_r      <= 1'b0;
            scorer_r      <= 1'b0;
            serve_cnt_r   <= CNT_ZERO;
            point_pulse_r <= 1'b0;
        end else if (tick) begin
            state_r       <= state_s;
            ball_x_r      <= ball_x_s;
            ball_y_r      <= ball_y_s;
            dx_right_r    <= dx_right_s;
            dy_down_r     <= dy_down_s;
            paddle0_r     <= paddle0_s;
            paddle1_r     <= paddle1_s;
            score0_r      <= score0_s;
            score1_r      <= score1_s;
            winner_r      <= winner_s;
            scorer_r      <= scorer_s;
            serve_cnt_r   <= serve_cnt_s;
            point_pulse_r <= pulse_s;
        end else begin
            point_pulse_r <= 1'b0;
        end
    end

    assign ball_x      = ball_x_r;
    assign ball_y      = ball_y_r;
    assign paddle0_x   = paddle0_r;
    assign paddle1_x   = paddle1_r;
    assign score0      = score0_r;
    assign score1      = score1_r;
    assign state       = state_r;
    assign point_pulse = point_pulse_r;
    assign winner      = winner_r;

endmodule

// File: tb/tb_pong_engine.sv
// Self-checking bench for pong_engine: directed scenarios plus random play against a behavioural model.
module tb_pong_engine;

    localparam int ST  = 4;
    localparam int WIN = 2;
    localparam int SP  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b0, start = 1'b0;
    logic p0l = 1'b0, p0r = 1'b0, p1l = 1'b0, p1r = 1'b0;
    logic [9:0] ball_x, paddle0_x, paddle1_x;
    logic [8:0] ball_y;
    logic [3:0] score0, score1;
    logic [2:0] state;
    logic       point_pulse, winner;

    int vectors = 0, miscompares = 0;
    bit check_en = 1'b0;

    int m_state, m_bx, m_by, m_p0, m_p1, m_s0, m_s1, m_pp, m_win, m_cnt, m_scorer, m_h0, m_h1;
    bit m_dxr, m_dyd;

    always #5 clk = ~clk;

    pong_engine #(.SERVE_TICKS(ST), .WIN_SCORE(WIN)) dut (
        .CLOCK_50(clk), .RESET(rst), .tick(tick), .start(start),
        .p0_left(p0l), .p0_right(p0r), .p1_left(p1l), .p1_right(p1r),
        .ball_x(ball_x), .ball_y(ball_y), .paddle0_x(paddle0_x), .paddle1_x(paddle1_x),
        .score0(score0), .score1(score1), .state(state),
        .point_pulse(point_pulse), .winner(winner)
    );

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        vectors++;
        if (act !== 32'(exp)) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic int step_of(input int hold);
`ifdef PONG_BOOST_EN
        return (1 + hold / 8 > 8) ? 8 : 1 + hold / 8;
`else
        return 4;
`endif
    endfunction

    function automatic int pmove(input int p, input bit l, input bit r, input int step);
        int d;
        d = (l == r) ? 0 : (r ? step : -step);
        return clampi(p + d, 8, 520);
    endfunction

    function automatic bit overlaps(input int bx, input int px);
        return (bx + 16 > px) && (bx < px + 112);
    endfunction

    task automatic centre_ball();
        m_bx = 312;
        m_by = 232;
    endtask

    task automatic model_reset();
        centre_ball();
        m_p0 = 264; m_p1 = 264; m_s0 = 0; m_s1 = 0; m_pp = 0; m_win = 0;
        m_state = 0; m_cnt = 0; m_scorer = 0; m_dxr = 1'b1; m_dyd = 1'b1; m_h0 = 0; m_h1 = 0;
    endtask

    task automatic model_tick();
        int st0, st1, nx, ny, sc;
        bit ndx, miss;
        m_pp = 0;
        if (!tick) return;
        st0 = step_of(m_h0);
        st1 = step_of(m_h1);
        m_h0 = (p0l ^ p0r) ? ((m_h0 < 63) ? m_h0 + 1 : 63) : 0;
        m_h1 = (p1l ^ p1r) ? ((m_h1 < 63) ? m_h1 + 1 : 63) : 0;
        case (m_state)
            0: begin
                m_s0 = 0; m_s1 = 0; centre_ball(); m_p0 = 264; m_p1 = 264;
                if (start) begin m_state = 1; m_cnt = ST; end
            end
            1: begin
                m_p0 = pmove(m_p0, p0l, p0r, st0);
                m_p1 = pmove(m_p1, p1l, p1r, st1);
                centre_ball();
                m_cnt = m_cnt - 1;
                if (m_cnt <= 0) begin m_state = 2; m_cnt = 0; end
            end
            2: begin
                miss = 1'b0; sc = 0;
                nx = m_bx + (m_dxr ? SP : -SP);
                ndx = m_dxr;
                if (nx < 8) begin nx = 8; ndx = 1'b1; end
                else if (nx > 616) begin nx = 616; ndx = 1'b0; end
                if (m_dyd) begin
                    ny = m_by + SP;
                    if (ny + 16 >= 472 && m_by + 16 <= 472 && overlaps(m_bx, m_p0)) begin
                        ny = 456; m_dyd = 1'b0;
                    end else if (ny >= 464) begin
                        miss = 1'b1; sc = 1;
                    end
                end else begin
                    ny = m_by - SP;
                    if (ny <= 8 && m_by >= 8 && overlaps(m_bx, m_p1)) begin
                        ny = 8; m_dyd = 1'b1;
                    end else if (ny < 0) begin
                        miss = 1'b1; sc = 0; ny = 0;
                    end
                end
                m_bx = nx;
                m_by = ny;
                if (miss) begin m_state = 3; m_scorer = sc; end
                else m_dxr = ndx;
                m_p0 = pmove(m_p0, p0l, p0r, st0);
                m_p1 = pmove(m_p1, p1l, p1r, st1);
            end
            3: begin
                if (m_scorer == 1) m_s1++; else m_s0++;
                m_win = m_scorer;
                m_pp = 1;
                if ((m_scorer == 1 ? m_s1 : m_s0) == WIN) m_state = 4;
                else begin
                    m_state = 1; m_cnt = ST; centre_ball(); m_dyd = (m_scorer == 1);
                end
            end
            default: begin
                if (start) begin
                    m_state = 0; m_s0 = 0; m_s1 = 0; centre_ball();
                    m_p0 = 264; m_p1 = 264; m_dxr = 1'b1; m_dyd = 1'b1;
                end
            end
        endcase
    endtask

    // One clock: apply tick, advance the model at the edge, return just after the falling edge
    task automatic cyc(input bit tk);
        tick = tk;
        @(posedge clk);
        if (rst) model_reset();
        else model_tick();
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("state", 32'(state), m_state);
            chk("ball_x", 32'(ball_x), m_bx);
            chk("ball_y", 32'(ball_y), m_by);
            chk("paddle0_x", 32'(paddle0_x), m_p0);
            chk("paddle1_x", 32'(paddle1_x), m_p1);
            chk("score0", 32'(score0), m_s0);
            chk("score1", 32'(score1), m_s1);
            chk("point_pulse", 32'(point_pulse), m_pp);
            chk("winner", 32'(winner), m_win);
        end
    end

    initial begin
        int pulses, budget;
        bit seen_point;
        model_reset();
        repeat (3) cyc(1'b0);
        check_en = 1'b1;
        rst = 1'b0;
        cyc(1'b1);
        chk("rst_ball_x", 32'(ball_x), 312);
        chk("rst_ball_y", 32'(ball_y), 232);
        chk("rst_paddle0", 32'(paddle0_x), 264);
        chk("rst_paddle1", 32'(paddle1_x), 264);
        chk("rst_state", 32'(state), 0);
        chk("rst_scores", 32'({score0, score1}), 0);
        chk("rst_pulse_winner", 32'({point_pulse, winner}), 0);

        // Serve sequence with start held
        start = 1'b1;
        cyc(1'b1);
        chk("serve_enter", 32'(state), 1);
        cyc(1'b0);
        for (int k = 2; k <= 5; k++) cyc(1'b1);
        chk("serve_to_play", 32'(state), 2);
        cyc(1'b1);
        chk("first_play_x", 32'(ball_x), 314);
        chk("first_play_y", 32'(ball_y), 234);
        start = 1'b0;

        // Player 0 parks at the left wall and misses twice
        p0l = 1'b1;
        pulses = 0;
        seen_point = 1'b0;
        budget = 600;
        while (m_state != 4 && budget > 0) begin
            cyc(1'b1);
            budget--;
            if (point_pulse) pulses++;
            if (m_state == 3 && !seen_point) begin
                seen_point = 1'b1;
                chk("miss_y", 32'(ball_y), 464);
            end
        end
        chk("match_budget", 32'(state), 4);
        chk("over_score1", 32'(score1), 2);
        chk("over_score0", 32'(score0), 0);
        chk("over_winner", 32'(winner), 1);
        chk("over_pulses", 32'(pulses), 2);
        chk("left_clamp", 32'(paddle0_x), 8);
        p0l = 1'b0;

        start = 1'b1;
        cyc(1'b1);
        chk("restart_idle", 32'(state), 0);
        chk("restart_score1", 32'(score1), 0);
        cyc(1'b1);
        chk("restart_serve", 32'(state), 1);
        start = 1'b0;

        // Right clamp, then both buttons
        p0r = 1'b1;
        repeat (150) cyc(1'b1);
        chk("right_clamp", 32'(paddle0_x), 520);
        p0l = 1'b1;
        repeat (3) cyc(1'b1);
        chk("both_no_move", 32'(paddle0_x), 520);
        p0l = 1'b0;
        p0r = 1'b0;

        // Asynchronous reset between edges
        rst = 1'b1;
        model_reset();
        #1;
        chk("arst_state", 32'(state), 0);
        chk("arst_ball", 32'({ball_x, ball_y}), (312 << 9) | 232);
        chk("arst_paddle0", 32'(paddle0_x), 264);
        chk("arst_scores", 32'({score0, score1}), 0);
        chk("arst_pulse", 32'(point_pulse), 0);
        cyc(1'b1);
        rst = 1'b0;

        // Random play
        for (int i = 0; i < 4000; i++) begin
            start = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) p0l = $urandom_range(0, 1);
            if ($urandom_range(0, 7) == 0) p0r = $urandom_range(0, 1);
            if ($urandom_range(0, 7) == 0) p1l = $urandom_range(0, 1);
            if ($urandom_range(0, 7) == 0) p1r = $urandom_range(0, 1);
            cyc($urandom_range(0, 3) != 0);
        end

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pong_engine.md
# pong_engine

Parametrised two-player game-state core for the VGA pong design. It owns ball position and direction, two paddles (bottom = player 0, top = player 1), scores and the match state machine, and updates once per `tick` strobe. It exports only coordinates, scores and state; the pixel renderer and `hvsync_generator` stay outside it. Collision is computed arithmetically from coordinates, not by sampling the raster.

## Interface
- `H_RES`, 640, field width in pixels
- `V_RES`, 480, field height in pixels
- `XW`, 10, width of x coordinates
- `YW`, 9, width of y coordinates
- `BORDER`, 8, side-wall thickness; also paddle thickness
- `BALL_SIZE`, 16, ball edge length
- `PADDLE_LEN`, 112, paddle length
- `BALL_SPEED`, 2, ball pixels per tick on each axis
- `PADDLE_STEP`, 4, paddle pixels per tick (fixed step)
- `SERVE_TICKS`, 60, ticks the ball is held before play
- `SCORE_W`, 4, score counter width
- `WIN_SCORE`, 9, score that ends the match

Ports:
- `CLOCK_50` in 1: sole clock
- `RESET` in 1: asynchronous, active-high
- `tick` in 1: single-cycle update strobe; back-to-back pulses are legal
- `start` in 1: level, active-high, already synchronised
- `p0_left`, `p0_right`, `p1_left`, `p1_right` in 1 each: level, active-high
- `ball_x` out XW; `ball_y` out YW: ball top-left corner
- `paddle0_x`, `paddle1_x` out XW: paddle left edges
- `score0`, `score1` out SCORE_W
- `state` out 3: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4
- `point_pulse` out 1: one-cycle pulse on each score change
- `winner` out 1: player who scored last; valid in OVER

## Operation
- **Reset values:** `ball_x`=(H_RES−BALL_SIZE)/2=312; `ball_y`=(V_RES−BALL_SIZE)/2=232; both paddles=(H_RES−PADDLE_LEN)/2=264; scores 0; `state` IDLE; `point_pulse` 0; `winner` 0. Internal directions reset to x right, y down.
- **State transitions:** every state change and register update happens only on a tick.
  - **IDLE:** scores cleared; ball and paddles centred. `start`=1 → SERVE.
  - **SERVE:** ball held at centre; serve counter loads SERVE_TICKS on entry and decrements each tick. Counter at 0 → PLAY. Paddles movable.
  - **PLAY:** ball and paddles update every tick.
  - **POINT:** single tick. Scorer's score increments and `winner` is set to the scorer. If the new score equals WIN_SCORE → OVER; otherwise → SERVE with the ball recentred, y direction toward the player who lost the point and x direction unchanged.
  - **OVER:** all positions frozen. `start`=1 → IDLE. If `start` is still held, IDLE → SERVE on the following tick.
- **Paddles (SERVE and PLAY):**
  - Exactly one of left/right asserted moves the paddle by the step.
  - Both or neither asserted: no move.
  - Position is clamped to [BORDER, H_RES−BORDER−PADDLE_LEN] = [8, 520] with no wrap.
- **Ball x:** next = x ± BALL_SPEED.
  - Next below BORDER → x=BORDER, direction becomes right.
  - Next above H_RES−BORDER−BALL_SIZE (616) → x=616, direction becomes left.
- **Ball y moving down:**
  - Paddle-0 top is at P0Y=V_RES−BORDER=472.
  - If next bottom ≥ P0Y, current bottom ≤ P0Y, and x ranges overlap (`ball_x`+BALL_SIZE > `paddle0_x` and `ball_x` < `paddle0_x`+PADDLE_LEN): y=P0Y−BALL_SIZE, direction becomes up.
  - Otherwise, if next y ≥ V_RES−BALL_SIZE: miss, player 1 scores → POINT.
- **Ball y moving up:** mirror of the above.
  - Paddle-1 bottom is at BORDER=8.
  - Overlap → y=BORDER, direction becomes down.
  - If y < BALL_SPEED: miss, player 0 scores → POINT.
  - The miss check uses compare-before-subtract, so no underflow.
- **Simultaneous events:** a corner hit reflects both axes in the same tick. A miss takes priority over the x reflection, and the x position is still updated.
- **Overlap evaluation:** uses paddle positions from before this tick's paddle move.

## Timing
- All outputs are registered. Updates become visible in the cycle after the `tick` cycle (latency 1).
- Inputs are sampled only in `tick` cycles.
- `point_pulse` is high for exactly the cycle in which the score output changes.
- `RESET` asserted at any time, including mid-PLAY, forces reset values immediately. The first tick after release is handled as IDLE.

## Configuration
- `PONG_BOOST_EN` defined: per-player hold counter counts ticks while exactly one button is held.
  - Step = min(1 + hold/8, 8).
  - Counter clears when the button is released or the press is ambiguous (both held).
- Undefined: step is fixed at PADDLE_STEP and no hold counters exist.

## Test plan
- **Reset:** assert `RESET` mid-PLAY → all outputs return to reset values on the next cycle without waiting for a tick; `state`=0.
- **Serve:** SERVE_TICKS=4, `start` held, 6 ticks → `state` 1 after tick 1, 2 after tick 5; after tick 6, `ball_x`=314 and `ball_y`=234.
- **Wall bounce:** ball x=615 moving right, tick → x=616, direction left; next tick → x=614.
- **Paddle hit/miss:** ball bottom 470 moving down, `paddle0_x`=264, `ball_x`=300 → y=456, direction up. Same with `paddle0_x`=8 → y reaches 464, `point_pulse` fires, `score1`=1, `state` SERVE.
- **Paddle clamp:** `paddle0_x`=518 with `p0_right` held → 520, then stays 520. Both buttons held → no move.
- **Match end:** WIN_SCORE=2, two player-0 misses → `score1`=2, `state`=4, `winner`=1. `start` tick → IDLE with scores 0. With `PONG_BOOST_EN`, 16 held ticks → step 3.
